// File: rtl/mem_lsu_if.sv
// Command, memory and completion signals of the load/store unit, bundled so the
// unit and its environment share one definition. state: IDLE=0 BEAT0=1 BEAT1=2 DONE=3.
interface mem_lsu_if;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_io_rsp;

  // Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready;
  // a memory beat completes on a rising edge with mem_req.valid && mem_rsp.valid.
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_is_store;
  logic [1:0]   cmd_size;
  logic         cmd_unsigned;
  logic [31:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  memory_io_req mem_req;
  memory_io_rsp mem_rsp;
  logic         done_valid;
  logic [31:0]  done_rdata;
  logic         done_err;
  logic [1:0]   state;

  modport master (
    output cmd_valid, cmd_is_store, cmd_size, cmd_unsigned, cmd_addr, cmd_wdata, mem_rsp,
    input  cmd_ready, mem_req, done_valid, done_rdata, done_err, state
  );

  modport slave (
    input  cmd_valid, cmd_is_store, cmd_size, cmd_unsigned, cmd_addr, cmd_wdata, mem_rsp,
    output cmd_ready, mem_req, done_valid, done_rdata, done_err, state
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: turns byte/half/word accesses at any alignment into one or two
// aligned 32-bit memory beats, with per-beat timeout and load extension.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit SIGN_EXT_EN    = 1'b1
) (
  input logic      clk,
  input logic      reset_n,
  mem_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, DONE = 2'd3} state_t;

  state_t       state_q, state_d;
  logic         is_store_q, unsigned_q, err_q;
  logic [1:0]   size_q, off_q;
  logic [29:0]  addr_q;
  logic [7:0]   mask_q;
  logic [63:0]  wdata_q, rbuf_q;
  logic [7:0]   wait_q;

  logic         accept, rsp_hit, timeout, sext;
  logic [7:0]   base_mask;
  logic [31:0]  shifted, result;

  logic         ready, req_valid, dv, de;
  logic [31:0]  req_addr, req_data, dr;
  logic [3:0]   req_rd, req_wr;

  assign accept  = bus.cmd_valid && ready;
  assign rsp_hit = bus.mem_rsp.valid;
  assign timeout = (wait_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (bus.cmd_size == 2'b11) ? DONE : BEAT0;
      BEAT0: begin
        if (rsp_hit)      state_d = (mask_q[7:4] != 4'h0) ? BEAT1 : DONE;
        else if (timeout) state_d = DONE;
      end
      BEAT1: if (rsp_hit || timeout) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (bus.cmd_size)
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_store_q <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      wait_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          is_store_q <= bus.cmd_is_store;
          unsigned_q <= bus.cmd_unsigned;
          size_q     <= bus.cmd_size;
          off_q      <= bus.cmd_addr[1:0];
          addr_q     <= bus.cmd_addr[31:2];
          mask_q     <= base_mask << bus.cmd_addr[1:0];
          wdata_q    <= {32'h0, bus.cmd_wdata} << {bus.cmd_addr[1:0], 3'b000};
          rbuf_q     <= '0;
          wait_q     <= '0;
          err_q      <= (bus.cmd_size == 2'b11);
        end
        BEAT0, BEAT1: begin
          // A response wins over a timeout expiring on the same edge.
          if (rsp_hit) begin
            wait_q <= '0;
            if (!is_store_q) begin
              if (state_q == BEAT0) rbuf_q[31:0]  <= bus.mem_rsp.data;
              else                  rbuf_q[63:32] <= bus.mem_rsp.data;
            end
          end else if (timeout) begin
            err_q  <= 1'b1;
            wait_q <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign shifted = 32'(rbuf_q >> {off_q, 3'b000});
  assign sext    = SIGN_EXT_EN && !unsigned_q;

  always_comb begin
    case (size_q)
      2'b00:   result = {{24{sext & shifted[7]}},  shifted[7:0]};
      2'b01:   result = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_rd    = '0;
    req_wr    = '0;
    dv        = 1'b0;
    de        = 1'b0;
    dr        = '0;
    case (state_q)
      IDLE:  ready = reset_n;
      BEAT0: begin
        req_valid = 1'b1;
        req_addr  = {addr_q, 2'b00};
        req_data  = wdata_q[31:0];
        req_rd    = is_store_q ? 4'h0 : mask_q[3:0];
        req_wr    = is_store_q ? mask_q[3:0] : 4'h0;
      end
      BEAT1: begin
        req_valid = 1'b1;
        req_addr  = {addr_q, 2'b00} + 32'd4;
        req_data  = wdata_q[63:32];
        req_rd    = is_store_q ? 4'h0 : mask_q[7:4];
        req_wr    = is_store_q ? mask_q[7:4] : 4'h0;
      end
      DONE: begin
        dv = 1'b1;
        de = err_q;
        dr = (err_q || is_store_q) ? 32'h0 : result;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready        = ready;
  assign bus.mem_req.valid    = req_valid;
  assign bus.mem_req.addr     = req_addr;
  assign bus.mem_req.data     = req_data;
  assign bus.mem_req.do_read  = req_rd;
  assign bus.mem_req.do_write = req_wr;
  assign bus.done_valid       = dv;
  assign bus.done_rdata       = dr;
  assign bus.done_err         = de;
  assign bus.state            = state_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a vector table of single/split/illegal accesses
// against a combinational word memory, plus timeout, late-response, idle and reset sequences.
module tb_mem_lsu;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT1 = 2'd2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_lsu_if bus();
  mem_lsu #(.TIMEOUT_CYCLES(4), .SIGN_EXT_EN(1'b1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [31:0] mem [0:255];
  logic        rsp_en, rsp_force;
  assign bus.mem_rsp.valid = rsp_force || (rsp_en && bus.mem_req.valid);
  assign bus.mem_rsp.addr  = 32'h0;
  assign bus.mem_rsp.data  = mem[bus.mem_req.addr[9:2]];

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        is_store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  m0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  m1;
    logic [31:0] d1;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] ad, input logic [31:0] wd);
    bus.cmd_is_store = st;
    bus.cmd_size     = sz;
    bus.cmd_unsigned = un;
    bus.cmd_addr     = ad;
    bus.cmd_wdata    = wd;
    bus.cmd_valid    = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int nb, k;
    logic seen, got_err;
    logic [31:0] got_rdata;
    logic [31:0] ba[2], bd[2];
    logic [3:0]  brd[2], bwr[2];
    @(negedge clk);
    check({tag, ".ready"}, 64'(bus.cmd_ready), 64'd1);
    drive_cmd(v.is_store, v.size, v.uns, v.addr, v.wdata);
    exp_q.push_back(v.rdata);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    nb = 0; k = 0; seen = 1'b0; got_err = 1'b0; got_rdata = '0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_req.valid) begin
        if (nb < 2) begin
          ba[nb]  = bus.mem_req.addr;
          bd[nb]  = bus.mem_req.data;
          brd[nb] = bus.mem_req.do_read;
          bwr[nb] = bus.mem_req.do_write;
        end
        nb++;
      end
      if (bus.done_valid) begin
        seen = 1'b1; k = c;
        got_rdata = bus.done_rdata;
        got_err   = bus.done_err;
      end
    end
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check({tag, ".beats"}, 64'(nb), 64'(v.beats));
    check({tag, ".latency"}, 64'(k), 64'(v.lat));
    if (v.beats >= 1 && nb >= 1) begin
      check({tag, ".addr0"}, 64'(ba[0]), 64'(v.a0));
      check({tag, ".rd0"}, 64'(brd[0]), 64'(v.is_store ? 4'h0 : v.m0));
      check({tag, ".wr0"}, 64'(bwr[0]), 64'(v.is_store ? v.m0 : 4'h0));
      check({tag, ".data0"}, 64'(bd[0]), 64'(v.d0));
    end
    if (v.beats == 2 && nb >= 2) begin
      check({tag, ".addr1"}, 64'(ba[1]), 64'(v.a1));
      check({tag, ".rd1"}, 64'(brd[1]), 64'(v.is_store ? 4'h0 : v.m1));
      check({tag, ".wr1"}, 64'(bwr[1]), 64'(v.is_store ? v.m1 : 4'h0));
      check({tag, ".data1"}, 64'(bd[1]), 64'(v.d1));
    end
    check({tag, ".err"}, 64'(got_err), 64'(v.err));
    check({tag, ".rdata"}, 64'(got_rdata), 64'(exp_q.pop_front()));
    @(negedge clk);
    check({tag, ".pulse_end"}, {bus.done_valid, bus.done_err, bus.done_rdata}, 64'd0);
  endtask

  // Word load at 0x100; the responder is enabled at cycle respond_at (0 = never).
  task automatic run_manual(input string tag, input int respond_at, input int exp_valid_cycles,
                            input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
    int nv, k;
    logic seen, got_err;
    logic [31:0] got_rdata;
    @(negedge clk);
    check({tag, ".ready"}, 64'(bus.cmd_ready), 64'd1);
    rsp_en = 1'b0;
    drive_cmd(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    exp_q.push_back(exp_rdata);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    nv = 0; k = 0; seen = 1'b0; got_err = 1'b0; got_rdata = '0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_req.valid) begin
        nv++;
        check({tag, ".addr_hold"}, 64'(bus.mem_req.addr), 64'h100);
      end
      if (bus.done_valid) begin
        seen = 1'b1; k = c;
        got_rdata = bus.done_rdata;
        got_err   = bus.done_err;
      end
      if (c == respond_at) rsp_en = 1'b1;
    end
    rsp_en = 1'b1;
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check({tag, ".valid_cycles"}, 64'(nv), 64'(exp_valid_cycles));
    check({tag, ".latency"}, 64'(k), 64'(exp_lat));
    check({tag, ".err"}, 64'(got_err), 64'(exp_err));
    check({tag, ".rdata"}, 64'(got_rdata), 64'(exp_q.pop_front()));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h100,      32'h0,        1, 32'h100,      4'b1111, 32'h0,        32'h0,   4'h0,    32'h0,        32'h80FF1234, 1'b0, 2};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h103,      32'h0,        1, 32'h100,      4'b1000, 32'h0,        32'h0,   4'h0,    32'h0,        32'hFFFFFF80, 1'b0, 2};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h103,      32'h0,        1, 32'h100,      4'b1000, 32'h0,        32'h0,   4'h0,    32'h0,        32'h00000080, 1'b0, 2};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h102,      32'h0,        1, 32'h100,      4'b1100, 32'h0,        32'h0,   4'h0,    32'h0,        32'hFFFF80FF, 1'b0, 2};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h101,      32'h0,        1, 32'h100,      4'b0110, 32'h0,        32'h0,   4'h0,    32'h0,        32'h0000FF12, 1'b0, 2};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h101,      32'h0,        1, 32'h100,      4'b0010, 32'h0,        32'h0,   4'h0,    32'h0,        32'h00000012, 1'b0, 2};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h102,      32'h0,        2, 32'h100,      4'b1100, 32'h0,        32'h104, 4'b0011, 32'h0,        32'h778880FF, 1'b0, 3};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h103,      32'h0,        2, 32'h100,      4'b1000, 32'h0,        32'h104, 4'b0001, 32'h0,        32'hFFFF8880, 1'b0, 3};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h1FE,      32'hAABBCCDD, 2, 32'h1FC,      4'b1100, 32'hCCDD0000, 32'h200, 4'b0011, 32'h0000AABB, 32'h0,        1'b0, 3};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 32'h005,      32'h123456A5, 1, 32'h004,      4'b0010, 32'h3456A500, 32'h0,   4'h0,    32'h0,        32'h0,        1'b0, 2};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0,        2, 32'hFFFFFFFC, 4'b1100, 32'h0,        32'h0,   4'b0011, 32'h0,        32'hBBCC1122, 1'b0, 3};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h100,      32'h0,        0, 32'h0,        4'h0,    32'h0,        32'h0,   4'h0,    32'h0,        32'h0,        1'b1, 1};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h003,      32'h0000BEEF, 2, 32'h000,      4'b1000, 32'hEF000000, 32'h004, 4'b0001, 32'h000000BE, 32'h0,        1'b0, 3};
    vecs[13] = '{1'b1, 2'd3, 1'b0, 32'h1FE,      32'h12345678, 0, 32'h0,        4'h0,    32'h0,        32'h0,   4'h0,    32'h0,        32'h0,        1'b1, 1};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h80FF1234;
    mem[8'h41] = 32'h55667788;
    mem[8'hFF] = 32'h11223344;
    mem[8'h00] = 32'h99AABBCC;

    rsp_en = 1'b1;
    rsp_force = 1'b0;
    bus.cmd_valid = 1'b0;
    drive_cmd(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    bus.cmd_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.ready", 64'(bus.cmd_ready), 64'd0);
    check("rst.req_valid", 64'(bus.mem_req), 64'd0);
    check("rst.done", {bus.done_valid, bus.done_err, bus.done_rdata}, 64'd0);
    check("rst.state", 64'(bus.state), 64'(ST_IDLE));
    reset_n = 1'b1;
    #1 check("rst.ready_after", 64'(bus.cmd_ready), 64'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Responses while idle are ignored
    @(negedge clk);
    rsp_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_rsp.state", 64'(bus.state), 64'(ST_IDLE));
      check("idle_rsp.done", 64'(bus.done_valid), 64'd0);
    end
    rsp_force = 1'b0;

    run_manual("timeout", 0, 4, 5, 1'b1, 32'h0);
    run_vec(vecs[0], "after_timeout");
    run_manual("late_rsp", 4, 4, 5, 1'b0, 32'h80FF1234);

    // Reset dropped during BEAT1 of a split load
    @(negedge clk);
    rsp_en = 1'b1;
    drive_cmd(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rsp_en = 1'b0;
    #1;
    check("midrst.state_beat1", 64'(bus.state), 64'(ST_BEAT1));
    check("midrst.valid_before", 64'(bus.mem_req.valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst.valid_async", 64'(bus.mem_req.valid), 64'd0);
    check("midrst.state_async", 64'(bus.state), 64'(ST_IDLE));
    check("midrst.ready_in_reset", 64'(bus.cmd_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst.no_done", 64'(bus.done_valid), 64'd0);
    end
    reset_n = 1'b1;
    rsp_en = 1'b1;
    #1 check("midrst.ready_after", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    check("midrst.no_done_after", 64'(bus.done_valid), 64'd0);
    run_vec(vecs[6], "after_midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001: Parameter TIMEOUT_CYCLES, default 16, SHALL set the number of cycles a beat waits for mem_rsp.valid before aborting; legal range 1..255.
REQ-002: Parameter SIGN_EXT_EN, default 1, SHALL enable sign extension of loads when cmd_unsigned=0; when 0, all loads are zero-extended.
REQ-003: clk  in  1  single clock; all state updates on its rising edge.
REQ-004: reset_n  in  1  asynchronous, active-low reset.
REQ-005: cmd_valid  in  1  command present.
REQ-006: cmd_ready  out  1  block can accept a command.
REQ-007: cmd_is_store  in  1  1=store, 0=load.
REQ-008: cmd_size  in  2  00=byte, 01=half, 10=word; 11 is illegal.
REQ-009: cmd_unsigned  in  1  load zero-extend select.
REQ-010: cmd_addr  in  32  byte address, any alignment.
REQ-011: cmd_wdata  in  32  store data, right-justified.
REQ-012: mem_req  out  memory_io_req  fields valid, addr, data, do_read[3:0], do_write[3:0].
REQ-013: mem_rsp  in  memory_io_rsp  fields valid, data; addr is ignored.
REQ-014: done_valid  out  1  one-cycle completion pulse.
REQ-015: done_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-016: done_err  out  1  qualifies done_valid: timeout or illegal size.

Function
REQ-017: The block SHALL implement states IDLE, BEAT0, BEAT1 and DONE.
REQ-018: cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid && cmd_ready.
REQ-019: On accept, the block SHALL register all cmd_* inputs and compute:
  - off = addr[1:0]
  - n = 1, 2 or 4 bytes
  - 8-bit mask = ((1<<n)-1)<<off
  - 64-bit wdata = cmd_wdata<<(8*off)
REQ-020: An accepted command with cmd_size=11 SHALL go directly to DONE with done_err=1 and SHALL issue no mem_req.
REQ-021: In BEAT0, mem_req SHALL be driven as follows:
  - valid=1
  - addr={addr[31:2],2'b00}
  - do_read = mask[3:0] for loads, else 0
  - do_write = mask[3:0] for stores, else 0
  - data = wdata[31:0]
REQ-022: In BEAT1, mem_req SHALL be driven as in BEAT0 with addr+4, mask[7:4] and wdata[63:32].
REQ-023: mem_req fields SHALL be held stable while in a BEAT state; in IDLE and DONE, mem_req.valid, do_read and do_write SHALL all be 0.
REQ-024: A beat SHALL complete on the first rising edge in a BEAT state with mem_rsp.valid=1; a same-cycle (combinational) response is legal.
REQ-025: On BEAT0 completion, the block SHALL go to BEAT1 if mask[7:4]!=0, else to DONE.
REQ-026: On BEAT1 completion, the block SHALL go to DONE.
REQ-027: On each load beat completion, the block SHALL capture mem_rsp.data into the 64-bit read buffer half for that beat.
REQ-028: A per-beat wait counter SHALL clear on beat entry and increment each cycle without a response.
REQ-029: When the wait counter reaches TIMEOUT_CYCLES-1 with no response, the beat SHALL abort: go to DONE with done_err=1, and the remaining beat SHALL be skipped.
REQ-030: In DONE, done_valid SHALL be 1 for exactly one cycle, after which the state SHALL return to IDLE.
REQ-031: Load result SHALL be buffer>>(8*off), truncated to n bytes, then sign-extended from bit 8n-1 if SIGN_EXT_EN && !cmd_unsigned, else zero-extended.
REQ-032: Latency with a zero-wait responder SHALL be: accept at edge N, mem_req.valid in cycle N+1, done_valid in cycle N+2 for single-beat and N+3 for split commands.
REQ-033: done_rdata and done_err SHALL be 0 whenever done_valid=0.
REQ-034: mem_rsp.valid in IDLE or DONE SHALL be ignored.
REQ-035: Address wrap SHALL be mod 2^32: BEAT1 addr of 0xFFFFFFFC+4 = 0x00000000.

Reset
REQ-036: reset_n=0 SHALL immediately, without waiting for clk, force:
  - state=IDLE
  - mem_req all fields 0
  - done_valid=0, done_rdata=0, done_err=0
  - wait counter=0, buffers=0
REQ-037: cmd_ready SHALL be 0 while reset_n=0 and 1 on the first cycle after release.
REQ-038: Reset asserted mid-beat SHALL abandon the command with no done_valid pulse.

Verification
REQ-039: Aligned word load: addr 0x100, memory word 0x80FF1234 -> do_read=1111, done_rdata=0x80FF1234 at N+2, done_err=0.
REQ-040: Signed byte load: addr 0x103, byte3=0x80 -> do_read=1000; result 0xFFFFFF80; with cmd_unsigned=1, result 0x00000080.
REQ-041: Split word store: addr 0x1FE, wdata 0xAABBCCDD -> BEAT0 addr 0x1FC, do_write=1100, data[31:16]=0xCCDD; BEAT1 addr 0x200, do_write=0011, data[15:0]=0xAABB; done_valid at N+3.
REQ-042: Timeout: TIMEOUT_CYCLES=4, responder never responds -> mem_req.valid held for 4 cycles, then done_valid=1, done_err=1, done_rdata=0; next command accepted afterwards.
REQ-043: Illegal size 11 -> no mem_req.valid, done_err=1 at N+1.
REQ-044: reset_n dropped during BEAT1 -> mem_req.valid falls asynchronously, no done_valid, cmd_ready=1 after release.
